// File: rtl/event_latency_scoreboard.sv
// Multi-outstanding event latency scoreboard: pairs start/end events by ID against a free-running
// timestamp and emits {id, start_ts, end_ts, delta} records through a show-ahead FIFO.
// Optional: EVENT_TS_ORPHAN_CNT_EN builds the saturating orphan-end counter.
module event_latency_scoreboard #(
    parameter int ID_W      = 4,
    parameter int TS_W      = 64,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ID_W-1:0]   start_id,
    input  logic              end_valid,
    output logic              end_ready,
    input  logic [ID_W-1:0]   end_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [TS_W-1:0]   out_start_ts,
    output logic [TS_W-1:0]   out_end_ts,
    output logic [TS_W-1:0]   out_ts,
    output logic [ID_W:0]     pending_cnt,
    output logic [15:0]       orphan_cnt
);

    localparam int N_ID  = 1 << ID_W;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    localparam logic [TS_W-1:0]  TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(OUT_DEPTH);
    localparam logic [ID_W:0]    PEND_ONE = {{ID_W{1'b0}}, 1'b1};

    logic [TS_W-1:0]  cnt_q;
    logic [N_ID-1:0]  open_q;
    logic [TS_W-1:0]  start_ts_q [N_ID];
    logic [ID_W:0]    pending_q;

    logic [ID_W-1:0]  fifo_id    [OUT_DEPTH];
    logic [TS_W-1:0]  fifo_sts   [OUT_DEPTH];
    logic [TS_W-1:0]  fifo_ets   [OUT_DEPTH];
    logic [TS_W-1:0]  fifo_delta [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_nxt;
    logic             full_q;

    logic             start_fire;
    logic             end_fire;
    logic             end_hit;
    logic             match;
    logic             pop;
    logic [TS_W-1:0]  matched_ts;
    logic [TS_W-1:0]  delta;

    // An end only ever sees the registered open bits, so it cannot match a same-cycle start.
    assign start_ready = !open_q[start_id];
    assign start_fire  = start_valid && start_ready;
    assign end_ready   = !full_q;
    assign end_fire    = end_valid && !full_q;
    assign end_hit     = open_q[end_id];
    assign match       = end_fire && end_hit;
    assign matched_ts  = start_ts_q[end_id];
    assign delta       = cnt_q - matched_ts;

    assign out_valid    = (count_q != '0);
    assign pop          = out_valid && out_ready;
    assign out_id       = fifo_id[rd_ptr_q];
    assign out_start_ts = fifo_sts[rd_ptr_q];
    assign out_end_ts   = fifo_ets[rd_ptr_q];
    assign out_ts       = fifo_delta[rd_ptr_q];
    assign pending_cnt  = pending_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TS_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= '0;
        end else begin
            if (match) begin
                open_q[end_id] <= 1'b0;
            end
            if (start_fire) begin
                open_q[start_id] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_fire) begin
            start_ts_q[start_id] <= cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            case ({start_fire, match})
                2'b10:   pending_q <= pending_q + PEND_ONE;
                2'b01:   pending_q <= pending_q - PEND_ONE;
                default: pending_q <= pending_q;
            endcase
        end
    end

    always_comb begin
        count_nxt = count_q;
        case ({match, pop})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (match) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (match) begin
            fifo_id[wr_ptr_q]    <= end_id;
            fifo_sts[wr_ptr_q]   <= matched_ts;
            fifo_ets[wr_ptr_q]   <= cnt_q;
            fifo_delta[wr_ptr_q] <= delta;
        end
    end

`ifdef EVENT_TS_ORPHAN_CNT_EN
    logic [15:0] orphan_q;
    logic        orphan;

    assign orphan     = end_fire && !end_hit;
    assign orphan_cnt = orphan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orphan_q <= '0;
        end else if (orphan && (orphan_q != 16'hFFFF)) begin
            orphan_q <= orphan_q + 16'd1;
        end
    end
`else
    assign orphan_cnt = '0;
`endif

endmodule
